instruction_fetch_unit: RTL and testbench

Upstream neighbour of `control_unit`: owns the program counter and, on `fetch_enable` from the control unit, performs one instruction-memory read. It returns the instruction through a one-cycle `fetch_done`/`instruction_valid` pulse. It also supports PC redirect (branch/jump target load) and a bounded wait on instruction memory, with error reporting on timeout.

---
 rtl/instruction_fetch_unit.sv | 195 +++++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Owns the program counter. On a fetch_enable request from the control unit
// it issues one instruction-memory read, waits (bounded by MAX_WAIT) for the
// memory to answer, and reports the outcome through a one-cycle fetch_done
// pulse accompanied by either instruction_valid (data captured) or
// fetch_error (memory timed out). The PC can be redirected at any time with
// pc_load; a redirect always takes priority over the sequential +4 update.
//
// Parameters
//   RESET_PC           PC after reset, word aligned
//   MAX_WAIT           request cycles without imem_ready before abort (1..255)
//
// Ports
//   clk                clock, rising-edge active
//   reset              asynchronous, active-high reset
//   fetch_enable       fetch request from the control unit
//   fetch_done         one-cycle pulse: fetch finished (ok or error)
//   instruction_valid  one-cycle pulse with fetch_done on success
//   instruction        last successfully fetched instruction word
//   instr_pc           address that instruction came from
//   fetch_pc           address of the next fetch
//   fetch_error        one-cycle pulse with fetch_done on timeout
//   pc_load            redirect request
//   pc_load_value      redirect target (bits [1:0] forced to zero)
//   imem_req           instruction-memory read request
//   imem_addr          read address, stable while imem_req is high
//   imem_ready         memory presents imem_rdata this cycle
//   imem_rdata         read data
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        fetch_enable,
    output logic        fetch_done,
    output logic        instruction_valid,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic [31:0] fetch_pc,
    output logic        fetch_error,

    input  logic        pc_load,
    input  logic [31:0] pc_load_value,

    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDone,
        StRetire
    } state_e;

    // Counter value seen during the last permitted request cycle.
    localparam logic [7:0] WaitLast = 8'(MAX_WAIT - 1);

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic [31:0] instruction_q, instruction_d;
    logic [31:0] imem_addr_q, imem_addr_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        redirect_q, redirect_d;
    logic        imem_req_q, imem_req_d;
    logic        fetch_done_q, fetch_done_d;
    logic        instr_valid_q, instr_valid_d;
    logic        fetch_error_q, fetch_error_d;

    logic [31:0] load_target;

    // Low two bits of the redirect target are ignored.
    assign load_target = pc_load_value & 32'hFFFF_FFFC;

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        instr_pc_d    = instr_pc_q;
        instruction_d = instruction_q;
        imem_addr_d   = imem_addr_q;
        wait_cnt_d    = wait_cnt_q;
        redirect_d    = redirect_q | pc_load;
        fetch_done_d  = 1'b0;
        instr_valid_d = 1'b0;
        fetch_error_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (fetch_enable) begin
                    state_d     = StReq;
                    imem_addr_d = fetch_pc_q;
                    wait_cnt_d  = 8'd0;
                    // A redirect seen before this point is already folded into
                    // imem_addr; only one arriving from now on must block the
                    // +4 update of this fetch.
                    redirect_d  = pc_load;
                end
            end

            StReq: begin
                if (imem_ready) begin
                    state_d       = StDone;
                    instruction_d = imem_rdata;
                    instr_pc_d    = imem_addr_q;
                    fetch_done_d  = 1'b1;
                    instr_valid_d = 1'b1;
                    if (!redirect_q && !pc_load) begin
                        fetch_pc_d = imem_addr_q + 32'd4;
                    end
                end else if (wait_cnt_q == WaitLast) begin
                    state_d       = StDone;
                    fetch_done_d  = 1'b1;
                    fetch_error_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end

            StDone: begin
                state_d = StRetire;
            end

            StRetire: begin
                // Enable must drop before another fetch can start.
                if (!fetch_enable) begin
                    state_d    = StIdle;
                    redirect_d = 1'b0;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Redirect overrides any sequential update made above.
        if (pc_load) begin
            fetch_pc_d = load_target;
        end

        imem_req_d = (state_d == StReq);
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            fetch_pc_q    <= RESET_PC;
            instr_pc_q    <= 32'd0;
            instruction_q <= 32'd0;
            imem_addr_q   <= 32'd0;
            wait_cnt_q    <= 8'd0;
            redirect_q    <= 1'b0;
            imem_req_q    <= 1'b0;
            fetch_done_q  <= 1'b0;
            instr_valid_q <= 1'b0;
            fetch_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            instr_pc_q    <= instr_pc_d;
            instruction_q <= instruction_d;
            imem_addr_q   <= imem_addr_d;
            wait_cnt_q    <= wait_cnt_d;
            redirect_q    <= redirect_d;
            imem_req_q    <= imem_req_d;
            fetch_done_q  <= fetch_done_d;
            instr_valid_q <= instr_valid_d;
            fetch_error_q <= fetch_error_d;
        end
    end

    assign fetch_done        = fetch_done_q;
    assign instruction_valid = instr_valid_q;
    assign instruction       = instruction_q;
    assign instr_pc          = instr_pc_q;
    assign fetch_pc          = fetch_pc_q;
    assign fetch_error       = fetch_error_q;
    assign imem_req          = imem_req_q;
    assign imem_addr         = imem_addr_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Directed bench for instruction_fetch_unit: a table of fetch transactions
// with hand-computed results, followed by hand-written sequences for the
// held-enable and mid-request reset cases.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    logic        clk;
    logic        reset;
    logic        fetch_enable;
    logic        fetch_done;
    logic        instruction_valid;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic [31:0] fetch_pc;
    logic        fetch_error;
    logic        pc_load;
    logic [31:0] pc_load_value;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    int n_checks;
    int n_fail;

    instruction_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .MAX_WAIT (15)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .fetch_enable      (fetch_enable),
        .fetch_done        (fetch_done),
        .instruction_valid (instruction_valid),
        .instruction       (instruction),
        .instr_pc          (instr_pc),
        .fetch_pc          (fetch_pc),
        .fetch_error       (fetch_error),
        .pc_load           (pc_load),
        .pc_load_value     (pc_load_value),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ready        (imem_ready),
        .imem_rdata        (imem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          delay;      // REQ cycle index that sees imem_ready, -1 = never
        logic [31:0] rdata;
        bit          pre_load;   // redirect in IDLE before the fetch
        logic [31:0] pre_val;
        bit          mid_load;   // redirect during REQ
        int          load_at;
        logic [31:0] load_val;
        logic [31:0] exp_addr;
        int          exp_cycles;
        bit          exp_err;
        logic [31:0] exp_instr;
        logic [31:0] exp_ipc;
        logic [31:0] exp_fpc;
    } vec_t;

    localparam int NumVec = 8;
    vec_t vecs [NumVec];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_fetch(input int idx, input vec_t v);
        int   cycles;
        logic addr_ok;
        string p;
        p = $sformatf("v%0d", idx);

        if (v.pre_load) begin
            pc_load       = 1'b1;
            pc_load_value = v.pre_val;
            @(posedge clk); #1;
            pc_load       = 1'b0;
        end

        fetch_enable = 1'b1;
        @(posedge clk); #1;
        fetch_enable = 1'b0;

        cycles  = 0;
        addr_ok = 1'b1;
        while (imem_req && cycles < 100) begin
            if (imem_addr !== v.exp_addr) addr_ok = 1'b0;
            imem_ready    = (cycles == v.delay);
            imem_rdata    = (cycles == v.delay) ? v.rdata : 32'hDEAD_BEEF;
            pc_load       = v.mid_load && (cycles == v.load_at);
            pc_load_value = v.load_val;
            @(posedge clk); #1;
            imem_ready = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
            pc_load    = 1'b0;
            cycles++;
        end

        chk({p, " addr_stable"}, {31'd0, addr_ok}, 32'd1);
        chk({p, " req_cycles"}, cycles, v.exp_cycles);
        chk({p, " fetch_done"}, {31'd0, fetch_done}, 32'd1);
        chk({p, " instr_valid"}, {31'd0, instruction_valid}, {31'd0, !v.exp_err});
        chk({p, " fetch_error"}, {31'd0, fetch_error}, {31'd0, v.exp_err});
        chk({p, " instruction"}, instruction, v.exp_instr);
        chk({p, " instr_pc"}, instr_pc, v.exp_ipc);
        chk({p, " fetch_pc"}, fetch_pc, v.exp_fpc);

        @(posedge clk); #1;
        chk({p, " done_pulse_end"}, {31'd0, fetch_done}, 32'd0);
        // RETIRE -> IDLE with enable low.
        @(posedge clk); #1;
    endtask

    initial begin
        int   k;
        logic done_seen;
        n_checks = 0;
        n_fail   = 0;

        //            delay rdata         pre  pre_val        mid at load_val    addr          cyc err instr         ipc           fpc
        vecs[0] = '{0,  32'h0640_0093, 0, 32'h0,         0, 0, 32'h0,     32'h0000_0000, 1,  0, 32'h0640_0093, 32'h0000_0000, 32'h0000_0004};
        vecs[1] = '{3,  32'h00A0_0113, 0, 32'h0,         0, 0, 32'h0,     32'h0000_0004, 4,  0, 32'h00A0_0113, 32'h0000_0004, 32'h0000_0008};
        vecs[2] = '{-1, 32'h0,         0, 32'h0,         0, 0, 32'h0,     32'h0000_0008, 15, 1, 32'h00A0_0113, 32'h0000_0004, 32'h0000_0008};
        vecs[3] = '{2,  32'h1111_1111, 0, 32'h0,         1, 1, 32'h103,   32'h0000_0008, 3,  0, 32'h1111_1111, 32'h0000_0008, 32'h0000_0100};
        vecs[4] = '{0,  32'h2222_2222, 0, 32'h0,         0, 0, 32'h0,     32'h0000_0100, 1,  0, 32'h2222_2222, 32'h0000_0100, 32'h0000_0104};
        vecs[5] = '{1,  32'h3333_3333, 0, 32'h0,         1, 1, 32'h200,   32'h0000_0104, 2,  0, 32'h3333_3333, 32'h0000_0104, 32'h0000_0200};
        vecs[6] = '{0,  32'h4444_4444, 1, 32'hFFFF_FFFE, 0, 0, 32'h0,     32'hFFFF_FFFC, 1,  0, 32'h4444_4444, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[7] = '{0,  32'h5555_5555, 0, 32'h0,         0, 0, 32'h0,     32'h0000_0000, 1,  0, 32'h5555_5555, 32'h0000_0000, 32'h0000_0004};

        reset         = 1'b1;
        fetch_enable  = 1'b0;
        pc_load       = 1'b0;
        pc_load_value = 32'd0;
        imem_ready    = 1'b0;
        imem_rdata    = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;

        chk("rst fetch_pc", fetch_pc, 32'h0);
        chk("rst instruction", instruction, 32'h0);
        chk("rst instr_pc", instr_pc, 32'h0);
        chk("rst imem_addr", imem_addr, 32'h0);
        chk("rst imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst fetch_done", {31'd0, fetch_done}, 32'd0);
        chk("rst instr_valid", {31'd0, instruction_valid}, 32'd0);
        chk("rst fetch_error", {31'd0, fetch_error}, 32'd0);

        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NumVec; i++) begin
            run_fetch(i, vecs[i]);
        end

        // Held enable: a single fetch, then nothing until enable cycles low.
        fetch_enable = 1'b1;
        @(posedge clk); #1;
        chk("hold req_up", {31'd0, imem_req}, 32'd1);
        chk("hold addr", imem_addr, 32'h4);
        imem_ready = 1'b1;
        imem_rdata = 32'h6666_6666;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        chk("hold done", {31'd0, fetch_done}, 32'd1);
        chk("hold fetch_pc", fetch_pc, 32'h8);
        k = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (imem_req !== 1'b0) k++;
        end
        chk("hold no_refetch", k, 32'd0);
        fetch_enable = 1'b0;
        @(posedge clk); #1;
        chk("hold req_low_idle", {31'd0, imem_req}, 32'd0);
        fetch_enable = 1'b1;
        @(posedge clk); #1;
        fetch_enable = 1'b0;
        chk("refetch req", {31'd0, imem_req}, 32'd1);
        chk("refetch addr", imem_addr, 32'h8);

        // Reset in the middle of the request.
        #2;
        reset = 1'b1;
        #1;
        chk("midrst imem_req", {31'd0, imem_req}, 32'd0);
        chk("midrst fetch_pc", fetch_pc, 32'h0);
        done_seen = fetch_done;
        @(posedge clk); #1;
        done_seen = done_seen | fetch_done;
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            done_seen = done_seen | fetch_done;
        end
        chk("midrst no_done", {31'd0, done_seen}, 32'd0);
        chk("midrst req_stays_low", {31'd0, imem_req}, 32'd0);
        chk("midrst instruction", instruction, 32'h0);
        chk("midrst instr_pc", instr_pc, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
